// File: rtl/tilemap_pkg.sv
// Shared tilemap definitions: map geometry defaults, bus widths and writer state encodings.
package tilemap_pkg;

  localparam int TILEMAP_LENGTH_DEF = 2000;
  localparam int TILEMAP_HEIGHT_DEF = 16;

  localparam int ADDR_W = 15;
  localparam int TILE_W = 4;
  localparam int X_W    = 11;
  localparam int Y_W    = 4;

  localparam logic [TILE_W-1:0] TILE_EMPTY = '0;

  typedef enum logic [2:0] {
    ST_WAIT  = 3'd0,
    ST_CHECK = 3'd1,
    ST_WRITE = 3'd2,
    ST_READ  = 3'd3,
    ST_CMP   = 3'd4,
    ST_FILL  = 3'd5,
    ST_DONE  = 3'd6
  } state_e;

endpackage

// File: rtl/tile_address_calc.sv
// Combinational tile coordinate to linear address (x + y*LENGTH) plus map bounds check.
module tile_address_calc
  import tilemap_pkg::*;
#(
  parameter int LENGTH = TILEMAP_LENGTH_DEF,
  parameter int HEIGHT = TILEMAP_HEIGHT_DEF
) (
  input  logic [X_W-1:0]    x_i,
  input  logic [Y_W-1:0]    y_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              in_range_o
);

  // Out-of-range coordinates may wrap; callers gate on in_range_o.
  assign addr_o     = ADDR_W'(x_i) + ADDR_W'(y_i) * ADDR_W'(LENGTH);
  assign in_range_o = (int'(x_i) < LENGTH) && (int'(y_i) < HEIGHT);

endmodule

// File: rtl/tilemap_writer.sv
// Tilemap command engine: single bounds-checked tile write or whole-map fill.
// Optional read-back verification of single writes when TILEMAP_WRITER_READBACK_EN is defined.
module tilemap_writer
  import tilemap_pkg::*;
#(
  parameter int TILEMAP_LENGTH = TILEMAP_LENGTH_DEF,
  parameter int TILEMAP_HEIGHT = TILEMAP_HEIGHT_DEF
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              enable,
  input  logic              op_fill,
  input  logic [X_W-1:0]    x_location,
  input  logic [Y_W-1:0]    y_location,
  input  logic [TILE_W-1:0] tile_value,
  input  logic [TILE_W-1:0] memory_input,
  output logic [ADDR_W-1:0] memory_address,
  output logic [TILE_W-1:0] memory_data,
  output logic              memory_wren,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int FILL_LAST = TILEMAP_LENGTH * TILEMAP_HEIGHT - 1;

  state_e              state_q, state_d;
  logic [X_W-1:0]      x_q, x_d;
  logic [Y_W-1:0]      y_q, y_d;
  logic [TILE_W-1:0]   tile_q, tile_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                error_q, error_d;

  logic [ADDR_W-1:0]   calc_addr;
  logic                calc_in_range;

  tile_address_calc #(
    .LENGTH (TILEMAP_LENGTH),
    .HEIGHT (TILEMAP_HEIGHT)
  ) u_addr_calc (
    .x_i        (x_q),
    .y_i        (y_q),
    .addr_o     (calc_addr),
    .in_range_o (calc_in_range)
  );

`ifndef TILEMAP_WRITER_READBACK_EN
  logic unused_mem_input;
  assign unused_mem_input = ^memory_input;
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_WAIT;
      x_q     <= '0;
      y_q     <= '0;
      tile_q  <= TILE_EMPTY;
      cnt_q   <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      tile_q  <= tile_d;
      cnt_q   <= cnt_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    x_d            = x_q;
    y_d            = y_q;
    tile_d         = tile_q;
    cnt_d          = cnt_q;
    error_d        = error_q;
    memory_address = '0;
    memory_data    = TILE_EMPTY;
    memory_wren    = 1'b0;
    busy           = 1'b1;
    done           = 1'b0;

    case (state_q)
      ST_WAIT: begin
        busy = 1'b0;
        if (enable) begin
          x_d    = x_location;
          y_d    = y_location;
          tile_d = tile_value;
          if (op_fill) begin
            cnt_d   = '0;
            error_d = 1'b0;
            state_d = ST_FILL;
          end else begin
            state_d = ST_CHECK;
          end
        end
      end

      ST_CHECK: begin
        error_d = !calc_in_range;
        state_d = calc_in_range ? ST_WRITE : ST_DONE;
      end

      ST_WRITE: begin
        memory_wren    = 1'b1;
        memory_address = calc_addr;
        memory_data    = tile_q;
`ifdef TILEMAP_WRITER_READBACK_EN
        state_d        = ST_READ;
`else
        state_d        = ST_DONE;
`endif
      end

`ifdef TILEMAP_WRITER_READBACK_EN
      // Read data for the address presented in READ arrives during CMP.
      ST_READ: begin
        memory_address = calc_addr;
        state_d        = ST_CMP;
      end

      ST_CMP: begin
        error_d = (memory_input != tile_q);
        state_d = ST_DONE;
      end
`endif

      ST_FILL: begin
        memory_wren    = 1'b1;
        memory_address = cnt_q;
        memory_data    = tile_q;
        if (cnt_q == ADDR_W'(FILL_LAST)) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end

      ST_DONE: begin
        busy = 1'b0;
        done = 1'b1;
        if (!enable) begin
          state_d = ST_WAIT;
        end
      end

      default: begin
        busy    = 1'b0;
        state_d = ST_WAIT;
      end
    endcase
  end

  assign error = error_q;

endmodule

// File: tb/tb_tilemap_writer.sv
// Randomized self-checking bench for tilemap_writer against a coordinate-level reference model.
module tb_tilemap_writer;
  import tilemap_pkg::*;

  localparam int LEN = 2000;
  localparam int HGT = 16;
`ifdef TILEMAP_WRITER_READBACK_EN
  localparam int DONE_CYC = 5;
`else
  localparam int DONE_CYC = 3;
`endif

  logic              clock = 1'b0;
  logic              resetn = 1'b1;
  logic              enable = 1'b0;
  logic              op_fill = 1'b0;
  logic [X_W-1:0]    x_location = '0;
  logic [Y_W-1:0]    y_location = '0;
  logic [TILE_W-1:0] tile_value = '0;
  logic [TILE_W-1:0] memory_input = '0;
  logic [ADDR_W-1:0] memory_address;
  logic [TILE_W-1:0] memory_data;
  logic              memory_wren;
  logic              busy;
  logic              done;
  logic              error;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

  wr_t wlog[$];
  int  cyc = 0;
  int  viol = 0;

  logic [TILE_W-1:0] mem [0:32767];
  logic [ADDR_W-1:0] addr_s = '0;
  logic [TILE_W-1:0] data_s = '0;
  logic              wren_s = 1'b0;
  bit                rb_force = 1'b0;
  logic [TILE_W-1:0] rb_val = '0;

  tilemap_writer dut (
    .clock          (clock),
    .resetn         (resetn),
    .enable         (enable),
    .op_fill        (op_fill),
    .x_location     (x_location),
    .y_location     (y_location),
    .tile_value     (tile_value),
    .memory_input   (memory_input),
    .memory_address (memory_address),
    .memory_data    (memory_data),
    .memory_wren    (memory_wren),
    .busy           (busy),
    .done           (done),
    .error          (error)
  );

  always #5 clock = ~clock;

  // Memory model: bus sampled mid-cycle, write and 1-cycle read applied on the rising edge.
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (wren_s) mem[addr_s] <= data_s;
    memory_input <= rb_force ? rb_val : mem[addr_s];
  end

  always @(negedge clock) begin
    addr_s <= memory_address;
    data_s <= memory_data;
    wren_s <= memory_wren;
    if (memory_wren) wlog.push_back('{int'(memory_address), int'(memory_data), cyc});
    if (!busy && (memory_wren || memory_address != '0)) viol++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached (tests_run=%0d)", tests_run);
    $fatal(1);
  end

  task automatic run_single(input logic [X_W-1:0] x, input logic [Y_W-1:0] y,
                            input logic [TILE_W-1:0] t, input bit drop, input bit scramble,
                            output int first_done, output int done_cycles,
                            output logic err_seen, output int c0);
    @(negedge clock);
    wlog.delete();
    c0 = cyc;
    x_location = x; y_location = y; tile_value = t; op_fill = 1'b0; enable = 1'b1;
    first_done = -1; done_cycles = 0; err_seen = 1'bx;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      if (k == 1) begin
        if (drop) enable = 1'b0;
        if (scramble) begin
          x_location = X_W'($urandom); y_location = Y_W'($urandom);
          tile_value = TILE_W'($urandom); op_fill = 1'($urandom);
        end
      end
      if (done) begin
        if (first_done < 0) begin
          first_done = k;
          err_seen = error;
        end
        done_cycles++;
      end
      if (!drop && first_done >= 0 && k == first_done + 3) enable = 1'b0;
      if (first_done >= 0 && !done && !busy) break;
    end
    enable = 1'b0;
    op_fill = 1'b0;
  endtask

  task automatic test_reset();
    #1 resetn = 1'b0;
    #2;
    tests_run++;
    if ({done, error, busy, memory_wren, memory_address, memory_data} !== '0) begin
      tests_failed++;
      $display("FAIL reset_async: got done=%b err=%b busy=%b wren=%b addr=%0d data=%0d, need all 0",
               done, error, busy, memory_wren, memory_address, memory_data);
    end
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    tests_run++;
    if ({done, busy, memory_wren} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_idle: got done=%b busy=%b wren=%b, need 000", done, busy, memory_wren);
    end
  endtask

  task automatic test_single_basic();
    int fd, dc, c0;
    logic er;
    run_single(11'd5, 4'd3, 4'h2, 1'b0, 1'b0, fd, dc, er, c0);
    tests_run++;
    if (fd != DONE_CYC) begin
      tests_failed++;
      $display("FAIL basic_latency: done first in cycle %0d, need %0d", fd, DONE_CYC);
    end
    tests_run++;
    if (wlog.size() != 1 || wlog[0].addr != 6005 || wlog[0].data != 2 || wlog[0].cyc - c0 != 2) begin
      tests_failed++;
      $display("FAIL basic_write: got %0d writes (addr=%0d data=%0d cyc=%0d), need 1 at addr 6005 data 2 cycle 2",
               wlog.size(), wlog.size() ? wlog[0].addr : -1, wlog.size() ? wlog[0].data : -1,
               wlog.size() ? wlog[0].cyc - c0 : -1);
    end
    tests_run++;
    if (er !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_error: got %b, need 0", er);
    end
    tests_run++;
    if (dc != 4) begin
      tests_failed++;
      $display("FAIL basic_done_hold: done high %0d cycles, need 4", dc);
    end
  endtask

  task automatic test_boundary();
    int fd, dc, c0;
    logic er;
    run_single(11'd1999, 4'd15, 4'h9, 1'b0, 1'b0, fd, dc, er, c0);
    tests_run++;
    if (wlog.size() != 1 || wlog[0].addr != 31999 || wlog[0].data != 9 || er !== 1'b0 || fd != DONE_CYC) begin
      tests_failed++;
      $display("FAIL bound_last_tile: writes=%0d addr=%0d err=%b done_cyc=%0d, need 1 at 31999 err 0 done %0d",
               wlog.size(), wlog.size() ? wlog[0].addr : -1, er, fd, DONE_CYC);
    end
    run_single(11'd2000, 4'd0, 4'h1, 1'b0, 1'b0, fd, dc, er, c0);
    tests_run++;
    if (wlog.size() != 0 || er !== 1'b1 || fd != 2) begin
      tests_failed++;
      $display("FAIL bound_x_2000: writes=%0d err=%b done_cyc=%0d, need 0 writes err 1 done 2",
               wlog.size(), er, fd);
    end
    run_single(11'd2047, 4'd15, 4'hF, 1'b0, 1'b0, fd, dc, er, c0);
    tests_run++;
    if (wlog.size() != 0 || er !== 1'b1) begin
      tests_failed++;
      $display("FAIL bound_x_2047: writes=%0d err=%b, need 0 writes err 1", wlog.size(), er);
    end
  endtask

  task automatic test_random_single();
    for (int i = 0; i < 24; i++) begin
      int fd, dc, c0, xi, yi, ti;
      logic er;
      bit inr;
      xi = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1995, 2047)) : int'($urandom_range(0, 1999));
      yi = int'($urandom_range(0, 15));
      ti = int'($urandom_range(0, 15));
      inr = (xi < LEN) && (yi < HGT);
      run_single(X_W'(xi), Y_W'(yi), TILE_W'(ti), 1'b0, 1'b1, fd, dc, er, c0);
      tests_run++;
      if (fd != (inr ? DONE_CYC : 2)) begin
        tests_failed++;
        $display("FAIL rand%0d_latency: x=%0d y=%0d done cycle %0d, need %0d", i, xi, yi, fd, inr ? DONE_CYC : 2);
      end
      tests_run++;
      if (inr ? (wlog.size() != 1 || wlog[0].addr != xi + yi * LEN || wlog[0].data != ti) : (wlog.size() != 0)) begin
        tests_failed++;
        $display("FAIL rand%0d_write: x=%0d y=%0d t=%0d got %0d writes addr=%0d data=%0d, need %0d writes addr=%0d",
                 i, xi, yi, ti, wlog.size(), wlog.size() ? wlog[0].addr : -1,
                 wlog.size() ? wlog[0].data : -1, inr ? 1 : 0, xi + yi * LEN);
      end
      tests_run++;
      if (er !== !inr) begin
        tests_failed++;
        $display("FAIL rand%0d_error: x=%0d y=%0d got %b, need %b", i, xi, yi, er, !inr);
      end
    end
  endtask

  task automatic test_enable_drop();
    int fd, dc, c0;
    logic er;
    run_single(11'd100, 4'd7, 4'hA, 1'b1, 1'b0, fd, dc, er, c0);
    tests_run++;
    if (wlog.size() != 1 || wlog[0].addr != 100 + 7 * LEN || wlog[0].data != 10) begin
      tests_failed++;
      $display("FAIL drop_write: got %0d writes, need 1 at addr %0d", wlog.size(), 100 + 7 * LEN);
    end
    tests_run++;
    if (dc != 1 || fd != DONE_CYC) begin
      tests_failed++;
      $display("FAIL drop_done_pulse: done high %0d cycles from cycle %0d, need 1 from %0d", dc, fd, DONE_CYC);
    end
    @(negedge clock);
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL drop_back_to_wait: busy=%b done=%b, need 0 0", busy, done);
    end
  endtask

  task automatic test_fill();
    int k, bad;
    @(negedge clock);
    wlog.delete();
    op_fill = 1'b1; tile_value = 4'h7; enable = 1'b1;
    @(negedge clock);
    x_location = X_W'($urandom); tile_value = 4'h1; op_fill = 1'b0;
    for (k = 2; k <= 32100; k++) begin
      @(negedge clock);
      if (done) break;
    end
    tests_run++;
    if (k != 32001) begin
      tests_failed++;
      $display("FAIL fill_latency: done first in cycle %0d, need 32001", k);
    end
    tests_run++;
    if (error !== 1'b0) begin
      tests_failed++;
      $display("FAIL fill_error: got %b, need 0", error);
    end
    bad = 0;
    foreach (wlog[i]) begin
      if (wlog[i].addr != i || wlog[i].data != 7 || (i > 0 && wlog[i].cyc != wlog[i-1].cyc + 1)) bad++;
    end
    tests_run++;
    if (wlog.size() != 32000 || bad != 0) begin
      tests_failed++;
      $display("FAIL fill_writes: got %0d writes with %0d out of order/value/gap, need 32000 clean", wlog.size(), bad);
    end
    enable = 1'b0;
    repeat (2) @(negedge clock);
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL fill_release: busy=%b done=%b, need 0 0", busy, done);
    end
  endtask

  task automatic test_fill_abort();
    bit hit;
    hit = 1'b0;
    @(negedge clock);
    op_fill = 1'b1; tile_value = 4'h5; enable = 1'b1;
    for (int k = 0; k < 1100; k++) begin
      @(negedge clock);
      if (memory_wren && memory_address == 15'd1000) begin
        hit = 1'b1;
        break;
      end
    end
    tests_run++;
    if (!hit) begin
      tests_failed++;
      $display("FAIL abort_reach_1000: fill never reached address 1000");
    end
    #1 resetn = 1'b0;
    #1;
    tests_run++;
    if ({memory_wren, busy, done, memory_address} !== '0) begin
      tests_failed++;
      $display("FAIL abort_immediate: wren=%b busy=%b done=%b addr=%0d, need all 0",
               memory_wren, busy, done, memory_address);
    end
    enable = 1'b0; op_fill = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    wlog.delete();
    repeat (50) @(negedge clock);
    tests_run++;
    if (wlog.size() != 0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_no_resume: %0d writes after release, busy=%b, need 0 and 0", wlog.size(), busy);
    end
  endtask

`ifdef TILEMAP_WRITER_READBACK_EN
  task automatic test_readback();
    int fd, dc, c0;
    logic er;
    rb_force = 1'b1;
    rb_val = 4'h0;
    run_single(11'd42, 4'd2, 4'h3, 1'b0, 1'b0, fd, dc, er, c0);
    tests_run++;
    if (fd != 5 || er !== 1'b1) begin
      tests_failed++;
      $display("FAIL rb_mismatch: done cycle %0d err=%b, need 5 and 1", fd, er);
    end
    rb_val = 4'h3;
    run_single(11'd42, 4'd2, 4'h3, 1'b0, 1'b0, fd, dc, er, c0);
    tests_run++;
    if (fd != 5 || er !== 1'b0) begin
      tests_failed++;
      $display("FAIL rb_match: done cycle %0d err=%b, need 5 and 0", fd, er);
    end
    rb_force = 1'b0;
  endtask
`endif

  task automatic test_idle_bus();
    tests_run++;
    if (viol != 0) begin
      tests_failed++;
      $display("FAIL idle_bus: %0d idle cycles with wren or nonzero address, need 0", viol);
    end
  endtask

  initial begin
    test_reset();
    test_single_basic();
    test_boundary();
    test_random_single();
    test_enable_drop();
`ifdef TILEMAP_WRITER_READBACK_EN
    test_readback();
`endif
    test_fill();
    test_fill_abort();
    test_idle_bus();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
